// File: rtl/ic_req_download_pkg.sv
// Ring request-flit definitions shared by the I-cache request upload and download paths.
package ic_req_download_pkg;

  localparam int unsigned FLIT_W = 16;
  localparam int unsigned MSG_W  = 3 * FLIT_W;

  localparam logic [1:0] FLIT_RSVD = 2'b00;
  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_BODY = 2'b10;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

endpackage

// File: rtl/ic_req_download.sv
// Reassembles head/body/tail request flits into one 48-bit message and
// presents it to the memory side with a valid/ready handshake.
module ic_req_download
  import ic_req_download_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              v_flit_in,
  input  logic [1:0]        ctrl_in,
  output logic              download_rdy,
  output logic [MSG_W-1:0]  req_msg_out,
  output logic              v_req_msg_out,
  input  logic              mem_rdy,
  output logic              ic_req_download_state,
  output logic              proto_err,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BODY = 2'd1,
    WAIT_TAIL = 2'd2,
    FULL      = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [FLIT_W-1:0] head_q, body_q, tail_q;
  logic              head_we, body_we, tail_we;
  logic              clr_low, clr_all, err_nxt;
  logic              accept;

  // Ready comes from the state register only, so mem_rdy never reaches the flit side.
  assign download_rdy          = (state != FULL);
  assign v_req_msg_out         = (state == FULL);
  assign ic_req_download_state = (state != IDLE);
  assign accept                = v_flit_in && download_rdy;
  assign req_msg_out           = {head_q, body_q, tail_q};

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    state_nxt = state;
    head_we   = 1'b0;
    body_we   = 1'b0;
    tail_we   = 1'b0;
    clr_low   = 1'b0;
    clr_all   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (ctrl_in == FLIT_HEAD) begin
          head_we   = 1'b1;
          state_nxt = WAIT_BODY;
        end else begin
          err_nxt = 1'b1;
        end
      end
      WAIT_BODY, WAIT_TAIL: if (accept) begin
        if (ctrl_in == FLIT_HEAD) begin
          // A new head aborts the partial message and restarts assembly.
          head_we   = 1'b1;
          clr_low   = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = WAIT_BODY;
        end else if (state == WAIT_BODY && ctrl_in == FLIT_BODY) begin
          body_we   = 1'b1;
          state_nxt = WAIT_TAIL;
        end else if (state == WAIT_TAIL && ctrl_in == FLIT_TAIL) begin
          tail_we   = 1'b1;
          state_nxt = FULL;
        end else begin
          err_nxt = 1'b1;
        end
      end
      FULL: if (mem_rdy) begin
        clr_all   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      proto_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      proto_err <= err_nxt;
      if (err_nxt && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end

  // NOTE: the message register is reset because req_msg_out must read 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      body_q <= '0;
      tail_q <= '0;
    end else begin
      if (clr_all)      head_q <= '0;
      else if (head_we) head_q <= flit_in;
      if (clr_all || clr_low) body_q <= '0;
      else if (body_we)       body_q <= flit_in;
      if (clr_all || clr_low) tail_q <= '0;
      else if (tail_we)       tail_q <= flit_in;
    end
  end

endmodule
